// File: rtl/otp_seq_pkg.sv
// otp_seq_pkg: shared definitions for the one-time-pad APB sequencer.
//   otp_seq_state_e : sequencer FSM states
//   OTP_*_ADDR      : register addresses on the pad engine's APB slave port
package otp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_SETUP,
    ST_KEY_ACC,
    ST_DATA_SETUP,
    ST_DATA_ACC,
    ST_RD_SETUP,
    ST_RD_ACC,
    ST_RESP
  } otp_seq_state_e;

  localparam logic [31:0] OTP_KEY_ADDR    = 32'd0;
  localparam logic [31:0] OTP_DATA_ADDR   = 32'd1;
  localparam logic [31:0] OTP_RESULT_ADDR = 32'd2;

endpackage

// File: rtl/otp_rr_arbiter.sv
// otp_rr_arbiter: round-robin arbiter with a registered priority pointer.
//   pclk, preset : clock, asynchronous active-high reset
//   req          : pending requests
//   advance      : grant taken this cycle; pointer moves past the winner
//   grant        : one-hot winner (combinational, zero when no request)
//   grant_id     : index of the winner
//   grant_any    : at least one request pending
module otp_rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic                                      pclk,
  input  logic                                      preset,
  input  logic [NREQ-1:0]                           req,
  input  logic                                      advance,
  output logic [NREQ-1:0]                           grant,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
  output logic                                      grant_any
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] ptr;
  logic           found;

  assign grant_any = |req;

  // Search from the pointer upward, wrapping at NREQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx[IDW-1:0]]) begin
        found                 = 1'b1;
        grant[idx[IDW-1:0]]   = 1'b1;
        grant_id              = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ptr <= '0;
    end else if (advance && grant_any) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

endmodule

// File: rtl/otp_apb_sequencer.sv
// otp_apb_sequencer: shares the one-time-pad XOR engine between NREQ clients.
// Grants one requester round-robin, writes key (addr 0) and data (addr 1) to
// the engine over APB, reads the result (addr 2) and returns it on a
// valid/ready response channel.
//   pclk, preset                  : clock, asynchronous active-high reset
//   req_valid/req_key/req_data    : per-requester request, WIDTH-bit slices
//   req_ready                     : one-hot grant pulse, key/data captured
//   rsp_valid/rsp_ready           : response handshake
//   rsp_id/rsp_data/rsp_err       : served index, key^data, read timeout
//   paddr/psel/penable/pwrite     : APB master controls
//   pwdata/prdata/pready          : APB data and ready
// Optional build macro OTP_SEQ_TIMEOUT_EN: bound the result read to
// TIMEOUT_CYCLES access cycles and report rsp_err on expiry.
module otp_apb_sequencer
  import otp_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = 128,
  parameter int unsigned NREQ           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                      pclk,
  input  logic                                      preset,
  input  logic [NREQ-1:0]                           req_valid,
  input  logic [NREQ*WIDTH-1:0]                     req_key,
  input  logic [NREQ*WIDTH-1:0]                     req_data,
  output logic [NREQ-1:0]                           req_ready,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
  output logic [WIDTH-1:0]                          rsp_data,
  output logic                                      rsp_err,
  output logic [31:0]                               paddr,
  output logic                                      psel,
  output logic                                      penable,
  output logic                                      pwrite,
  output logic [WIDTH-1:0]                          pwdata,
  input  logic [WIDTH-1:0]                          prdata,
  input  logic                                      pready
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  otp_seq_state_e state;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic             take;
  logic [WIDTH-1:0] key_sel;
  logic [WIDTH-1:0] data_sel;
  logic [WIDTH-1:0] data_q;
  logic             rd_sample;
  logic             rd_timeout;

  otp_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .pclk      (pclk),
    .preset    (preset),
    .req       (req_valid),
    .advance   (take),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign take      = (state == ST_IDLE) && grant_any;
  // Grant is a handshake with the requester, so it is driven straight from
  // the arbiter while idle; reset forces it low along with everything else.
  assign req_ready = (state == ST_IDLE && !preset) ? grant : '0;

  always_comb begin
    key_sel  = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        key_sel  = req_key[i*WIDTH +: WIDTH];
        data_sel = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef OTP_SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] rd_cnt;   // access cycles already spent in RD_ACC
  logic          rsp_err_q;

  // The first access cycle never samples; expiry only if pready is not
  // taken on the last allowed cycle.
  assign rd_sample  = (rd_cnt != '0) && pready;
  assign rd_timeout = !rd_sample && (rd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_err    = rsp_err_q;
`else
  logic rd_first;          // set during the first RD_ACC cycle only

  assign rd_sample  = !rd_first && pready;
  assign rd_timeout = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
`ifdef OTP_SEQ_TIMEOUT_EN
      rd_cnt    <= '0;
      rsp_err_q <= 1'b0;
`else
      rd_first  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            rsp_id  <= grant_id;
            data_q  <= data_sel;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= OTP_KEY_ADDR;
            pwdata  <= key_sel;
            state   <= ST_KEY_SETUP;
          end
        end
        ST_KEY_SETUP: begin
          penable <= 1'b1;
          state   <= ST_KEY_ACC;
        end
        ST_KEY_ACC: begin
          penable <= 1'b0;
          paddr   <= OTP_DATA_ADDR;
          pwdata  <= data_q;
          state   <= ST_DATA_SETUP;
        end
        ST_DATA_SETUP: begin
          penable <= 1'b1;
          state   <= ST_DATA_ACC;
        end
        ST_DATA_ACC: begin
          penable <= 1'b0;
          pwrite  <= 1'b0;
          paddr   <= OTP_RESULT_ADDR;
          pwdata  <= '0;
          state   <= ST_RD_SETUP;
        end
        ST_RD_SETUP: begin
          penable  <= 1'b1;
`ifdef OTP_SEQ_TIMEOUT_EN
          rd_cnt   <= '0;
`else
          rd_first <= 1'b1;
`endif
          state    <= ST_RD_ACC;
        end
        ST_RD_ACC: begin
`ifdef OTP_SEQ_TIMEOUT_EN
          rd_cnt   <= rd_cnt + 1'b1;
`else
          rd_first <= 1'b0;
`endif
          if (rd_sample || rd_timeout) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            rsp_valid <= 1'b1;
            rsp_data  <= rd_sample ? prdata : '0;
`ifdef OTP_SEQ_TIMEOUT_EN
            rsp_err_q <= !rd_sample;
`endif
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_apb_sequencer.sv
// Testbench for otp_apb_sequencer: randomized and directed stimulus with a
// scoreboard. Expected responses are queued at grant time from the bench's
// own request values; a monitor compares them on each response handshake and
// checks grant order against a round-robin reference.
module tb_otp_apb_sequencer;

  localparam int W   = 128;
  localparam int N   = 3;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic             pclk = 1'b0;
  logic             preset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_key;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;
  logic             rsp_err;
  logic [31:0]      paddr;
  logic             psel, penable, pwrite;
  logic [W-1:0]     pwdata;
  logic [W-1:0]     prdata = '0;
  logic             pready = 1'b1;

  otp_apb_sequencer #(
    .WIDTH          (W),
    .NREQ           (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 pclk = ~pclk;

  // ---------------- bench state ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   gcnt[N];
  int   seen[N];
  bit   reissue[N];
  bit   busy = 0;
  int   mptr = 0;
  int   rsp_cnt = 0;
  bit   rand_on = 0;
  bit   exp_err = 0;
  int   pmode = 0;   // 0: pready high, 1: mostly high random, 2: pready low
  bit   hold = 0;
  logic [W-1:0]   h_data;
  logic [IDW-1:0] h_id;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- engine model ----------------
  // Key/data registers written on write access cycles; the result register
  // refreshes only on a read access edge, so the first read access cycle
  // still shows the previous result.
  logic [W-1:0] eng_key = '0;
  logic [W-1:0] eng_data = '0;

  always @(posedge pclk) begin
    if (psel && penable && pwrite) begin
      if (paddr == 32'd0) eng_key <= pwdata;
      else if (paddr == 32'd1) eng_data <= pwdata;
    end
    if (psel && penable && !pwrite) prdata <= eng_key ^ eng_data;
    pready <= (pmode == 0) ? 1'b1 : (pmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge pclk) begin
    if (preset) begin
      busy = 0;
      mptr = 0;
      hold = 0;
      exp_q.delete();
    end else begin
      if (hold) begin
        chk("rsp_hold_valid_id", {rsp_valid, rsp_id}, {1'b1, h_id});
        chk("rsp_hold_data", rsp_data, h_data);
        hold = 0;
      end
      if (busy) begin
        chk("no_grant_while_busy", req_ready, '0);
      end else if (|req_valid) begin
        int   w;
        exp_t e;
        w = rr_pick(mptr, req_valid);
        chk("grant_onehot", req_ready, N'(1) << w);
        e.id   = IDW'(w);
        e.data = exp_err ? '0 : (req_key[w*W +: W] ^ req_data[w*W +: W]);
        e.err  = exp_err;
        exp_q.push_back(e);
        grant_log.push_back(w);
        gcnt[w]++;
        mptr = (w + 1) % N;
        busy = 1;
      end else begin
        chk("no_grant_idle", req_ready, '0);
      end
      if (rsp_valid) begin
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got id %0d data %h, expected no response", rsp_id, rsp_data);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_id_err", {rsp_err, rsp_id}, {e.err, e.id});
            chk("rsp_data", rsp_data, e.data);
          end
          busy = 0;
          rsp_cnt++;
        end else begin
          hold   = 1;
          h_data = rsp_data;
          h_id   = rsp_id;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic raise(input int i);
    req_key[i*W +: W]  = {$urandom, $urandom, $urandom, $urandom};
    req_data[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
    req_valid[i]       = 1'b1;
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gcnt[i] != seen[i]) begin
        seen[i]      = gcnt[i];
        req_valid[i] = 1'b0;
        if (reissue[i]) raise(i);
      end else if (rand_on && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        raise(i);
      end
    end
    if (rand_on) rsp_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || |req_valid) && n < limit) begin
      tick();
      n++;
    end
    if (busy || |req_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", limit);
    end
  endtask

  function automatic logic [34:0] apb_ref(input int c);
    case (c)
      1: return {1'b1, 1'b0, 1'b1, 32'd0};
      2: return {1'b1, 1'b1, 1'b1, 32'd0};
      3: return {1'b1, 1'b0, 1'b1, 32'd1};
      4: return {1'b1, 1'b1, 1'b1, 32'd1};
      5: return {1'b1, 1'b0, 1'b0, 32'd2};
      default: return {1'b1, 1'b1, 1'b0, 32'd2};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] k1, d1;
    int n, start;

    for (int i = 0; i < N; i++) begin
      gcnt[i] = 0; seen[i] = 0; reissue[i] = 0;
    end
    preset    = 1'b1;
    req_valid = '0;
    req_key   = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, psel, penable, pwrite, paddr}, '0);
    chk("reset_pwdata", pwdata, '0);
    chk("reset_rsp_data", rsp_data, '0);
    preset = 1'b0;

    // Uncontended single request with exact APB timing.
    tick();
    rsp_ready = 1'b1;
    k1 = '1;
    d1 = {16{8'h0F}};
    req_key[0 +: W]  = k1;
    req_data[0 +: W] = d1;
    req_valid[0]     = 1'b1;
    @(negedge pclk);
    chk("seq_grant_c0", req_ready, 3'b001);
    for (int c = 1; c <= 8; c++) begin
      tick();
      @(negedge pclk);
      if (c <= 7) chk($sformatf("seq_apb_c%0d", c), {psel, penable, pwrite, paddr}, apb_ref(c));
      if (c <= 2) chk($sformatf("seq_pwdata_c%0d", c), pwdata, k1);
      else if (c <= 4) chk($sformatf("seq_pwdata_c%0d", c), pwdata, d1);
      chk($sformatf("seq_rsp_valid_c%0d", c), rsp_valid, (c == 8));
    end
    chk("seq_rsp_data", rsp_data, {16{8'hF0}});
    chk("seq_rsp_id", rsp_id, 0);
    chk("seq_apb_idle_c8", {psel, penable, pwrite, paddr}, '0);
    tick();
    raise(1);
    @(negedge pclk);
    chk("seq_next_grant_c9", req_ready, 3'b010);
    wait_idle(100);

    // Stale result in the engine with pready stuck high.
    tick(); raise(0); wait_idle(100);
    tick(); raise(2); wait_idle(100);

    // Two requesters held: grants alternate.
    tick();
    reissue[0] = 1; reissue[1] = 1;
    start = grant_log.size();
    raise(0); raise(1);
    n = 0;
    while (grant_log.size() < start + 5 && n < 300) begin tick(); n++; end
    reissue[0] = 0; reissue[1] = 0;
    wait_idle(100);
    for (int k = start + 1; k < start + 5 && k < grant_log.size(); k++)
      chk("held_alternate", grant_log[k], 1 - grant_log[k-1]);
    chk("held_progress", (grant_log.size() >= start + 5), 1);

    // Response held off for 5 cycles with another request pending.
    tick();
    rsp_ready = 1'b0;
    raise(0); raise(2);
    n = 0;
    do begin tick(); @(negedge pclk); n++; end while (!rsp_valid && n < 50);
    chk("stall_rsp_seen", rsp_valid, 1);
    repeat (5) tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge pclk);
    chk("stall_next_grant", |req_ready, 1);
    wait_idle(100);

    // Reset during DATA_ACC.
    tick();
    raise(1);
    repeat (4) tick();
    #1;
    chk("pre_rst_data_acc", {psel, penable, pwrite, paddr}, {1'b1, 1'b1, 1'b1, 32'd1});
    preset = 1'b1;
    #1;
    chk("rst_mid_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, psel, penable, pwrite, paddr}, '0);
    chk("rst_mid_pwdata", pwdata, '0);
    chk("rst_mid_rsp_data", rsp_data, '0);
    tick();
    preset = 1'b0;
    raise(1);
    wait_idle(100);

    // Read with pready held low.
    tick();
    pmode = 2;
    repeat (2) tick();
`ifdef OTP_SEQ_TIMEOUT_EN
    exp_err = 1;
    raise(0);
    n = 0;
    do begin tick(); @(negedge pclk); n++; end while (!rsp_valid && n < 60);
    chk("timeout_latency", n, 22);
    chk("timeout_err", rsp_err, 1);
    wait_idle(20);
    exp_err = 0;
    pmode = 0;
    repeat (2) tick();
`else
    raise(0);
    n = 0;
    repeat (40) begin tick(); @(negedge pclk); if (rsp_valid) n++; end
    chk("no_timeout_wait", n, 0);
    chk("no_timeout_rd_acc", {psel, penable, pwrite, paddr}, {1'b1, 1'b1, 1'b0, 32'd2});
    pmode = 0;
    wait_idle(50);
`endif

    // Randomized traffic.
    pmode = 1;
    rand_on = 1;
    repeat (400) tick();
    rand_on = 0;
    rsp_ready = 1'b1;
    wait_idle(300);
    chk("rand_progress", (rsp_cnt > 20), 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
